xpmwrap_sdpram_read_stream: RTL and testbench
=============================================

# xpmwrap_sdpram_read_stream

Read-side sequencer placed directly downstream of the byte-write simple dual-port RAM wrapper. It accepts a (start address, length) read command, drives the RAM's port-B read controls, and absorbs the fixed read latency. Returned words are presented as a valid/ready stream with a last flag and full backpressure. A credit-limited output FIFO guarantees that no returning word is ever dropped, while sustaining one word per cycle when the consumer is always ready.

## Interface
Parameters:
- ADDR_WIDTH_B, default 6: RAM port-B address width.
- READ_DATA_WIDTH_B, default 32: RAM read word width; same as the stream data width.
- READ_LATENCY_B, default 2: RAM read latency in cycles, counted from the enb cycle to the cycle doutb is valid. Legal range 1..4. It must equal the RAM instance setting.
- FIFO_DEPTH, default READ_LATENCY_B+2: number of output FIFO entries. Must be at least READ_LATENCY_B+1.

Ports:
- clkb  in  1  — single clock; clocks all logic and the RAM read port.
- rstb_n  in  1  — reset, asynchronous assert, active-low.
- cmd_addr  in  ADDR_WIDTH_B  — first word address.
- cmd_len  in  ADDR_WIDTH_B+1  — number of words; legal range 0..2^ADDR_WIDTH_B.
- cmd_valid  in  1  — command offered.
- cmd_ready  out  1  — command accepted when cmd_valid and cmd_ready are both high.
- addrb  out  ADDR_WIDTH_B  — RAM read address.
- enb  out  1  — RAM read enable; one read per cycle in which it is high.
- regceb  out  1  — RAM output register enable; tied to 1.
- doutb  in  READ_DATA_WIDTH_B  — RAM read data.
- m_data  out  READ_DATA_WIDTH_B  — stream data.
- m_valid  out  1  — stream data valid.
- m_last  out  1  — marks the final word of a command.
- m_ready  in  1  — consumer ready.
- busy  out  1  — high from command accept until done.
- done  out  1  — one-cycle pulse when a command completes.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. An accepted command with cmd_len≠0 goes to ISSUE; one with cmd_len=0 goes to FIN.
  - ISSUE: issues reads while credit>0. After the final read is issued, goes to DRAIN.
  - DRAIN: waits for the handshake (m_valid & m_ready) on the word with m_last=1, then goes to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Address: captured at command accept; increments by 1 on each issued read. It wraps modulo 2^ADDR_WIDTH_B (top address → 0).
- Remaining count: loaded with cmd_len and decremented on each issue. The read issued with remaining=1 carries last=1.
- Credit: credit = FIFO_DEPTH − (FIFO occupancy + reads in flight). enb is asserted only when credit>0. This makes FIFO overflow impossible, so a full FIFO never loses data.
- Latency pipeline: a READ_LATENCY_B-stage shift register carries {valid, last}. When the final stage is valid, {doutb, last} is pushed into the FIFO that same cycle.
- FIFO: first-word-fall-through. m_valid = not empty. Pop on m_valid & m_ready. A push and a pop in the same cycle keep occupancy unchanged.
- cmd_valid is ignored outside IDLE.
- busy = (state≠IDLE).
- Reset (rstb_n=0, at any time, including mid-command):
  - FSM returns to IDLE.
  - Pipeline and FIFO are cleared.
  - Outputs: cmd_ready=1, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, regceb=1.
  - In-flight RAM data arriving after reset release is ignored.

## Timing
- Command accepted at the clock edge ending cycle T:
  - First enb is high in cycle T+1, with addrb = cmd_addr.
  - The first word is pushed at the end of cycle T+1+READ_LATENCY_B.
  - m_valid rises in cycle T+2+READ_LATENCY_B (T+4 at the default latency).
- With m_ready held at 1: one enb per cycle and one output word per cycle, with no bubbles.
- With m_ready=0: issue continues until credit reaches 0, then stalls. m_data, m_valid and m_last hold stable until the handshake.
- done is high in the cycle after the last-word handshake. busy falls in the same cycle that done falls.
- For cmd_len=0: done is high in cycle T+1; no enb and no m_valid occur.
- Back-to-back commands: the next cmd_ready=1 comes in the cycle after done. Minimum gap is 2 cycles between the last handshake and the next accept.

## Test plan
- Basic read: cmd_addr=5, cmd_len=4, m_ready=1, RAM preloaded with mem[i]=i+0x100.
  - m_data = 0x105, 0x106, 0x107, 0x108 on consecutive cycles, starting at T+4.
  - m_last is high only on 0x108; done is high at T+8.
- Wrap-around: ADDR_WIDTH_B=6, cmd_addr=62, cmd_len=4.
  - addrb sequence is 62, 63, 0, 1.
  - Data order matches that address sequence; exactly 4 beats.
- Backpressure: cmd_len=10, m_ready=0 for 20 cycles, then toggled 1/0.
  - At most FIFO_DEPTH (4) enb pulses occur while stalled.
  - All 10 words arrive in order, with no loss or duplication.
  - m_data stays stable while m_valid=1 and m_ready=0.
- Zero and full length:
  - cmd_len=0 → no enb, no m_valid, done at T+1.
  - cmd_len=64 from address 0 → 64 beats covering addresses 0..63, with m_last on the 64th.
- Reset mid-command: assert rstb_n=0 after 3 beats of a 10-word command.
  - All outputs take their reset values immediately (asynchronously).
  - After release, no stale word appears; a new cmd_len=2 returns exactly 2 correct words.

Source files
------------

// File: rtl/xpmwrap_sdpram_read_stream_if.sv
// Bundle of command, RAM port-B and output stream signals
// for the SDPRAM read-stream sequencer.
interface xpmwrap_sdpram_read_stream_if #(
   parameter int ADDR_WIDTH_B      = 6,
   parameter int READ_DATA_WIDTH_B = 32
) ();
   logic [ADDR_WIDTH_B-1:0]      cmd_addr;
   logic [ADDR_WIDTH_B:0]        cmd_len;
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [ADDR_WIDTH_B-1:0]      addrb;
   logic                         enb;
   logic                         regceb;
   logic [READ_DATA_WIDTH_B-1:0] doutb;
   logic [READ_DATA_WIDTH_B-1:0] m_data;
   logic                         m_valid;
   logic                         m_last;
   logic                         m_ready;
   logic                         busy;
   logic                         done;

   modport slave (
      input  cmd_addr, cmd_len, cmd_valid, doutb, m_ready,
      output cmd_ready, addrb, enb, regceb,
      output m_data, m_valid, m_last, busy, done
   );

   modport master (
      output cmd_addr, cmd_len, cmd_valid, doutb, m_ready,
      input  cmd_ready, addrb, enb, regceb,
      input  m_data, m_valid, m_last, busy, done
   );
endinterface

// File: rtl/xpmwrap_sdpram_read_stream.sv
// Read-side sequencer for the byte-write SDPRAM wrapper:
// issues port-B reads under FIFO credit, streams words out.
module xpmwrap_sdpram_read_stream #(
   parameter int ADDR_WIDTH_B      = 6,
   parameter int READ_DATA_WIDTH_B = 32,
   parameter int READ_LATENCY_B    = 2,
   parameter int FIFO_DEPTH        = READ_LATENCY_B + 2
) (
   input logic clkb,
   input logic rstb_n,
   xpmwrap_sdpram_read_stream_if.slave bus
);
   localparam int AW = ADDR_WIDTH_B;
   localparam int DW = READ_DATA_WIDTH_B;
   localparam int L  = READ_LATENCY_B;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + L + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]    r_state;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_rem;
   logic [L-1:0]  r_pv;
   logic [L-1:0]  r_pl;
   logic [DW:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_cnt;

   logic [CW-1:0] w_infl;
   logic          w_enb;
   logic          w_last_in;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [DW:0]   w_head;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Count reads still travelling through the RAM latency.
   always_comb begin
      w_infl = '0;
      for (int i = 0; i < L; i++) begin
         w_infl = w_infl + CW'(r_pv[i]);
      end
   end

   assign w_enb     = (r_state == S_ISSUE) &&
                      ((r_cnt + w_infl) < CW'(FIFO_DEPTH));
   assign w_last_in = (r_rem == (AW+1)'(1));
   assign w_push    = r_pv[L-1];
   assign w_empty   = (r_cnt == '0);
   assign w_pop     = !w_empty && bus.m_ready;
   assign w_head    = r_mem[r_rp];

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.enb       = w_enb;
   assign bus.addrb     = r_addr;
   assign bus.regceb    = 1'b1;
   assign bus.m_valid   = !w_empty;
   assign bus.m_data    = w_empty ? '0 : w_head[DW-1:0];
   assign bus.m_last    = !w_empty && w_head[DW];
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_FIN);

   // Command FSM with address and remaining-word tracking.
   always_ff @(posedge clkb or negedge rstb_n) begin
      if (!rstb_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_rem   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_addr  <= bus.cmd_addr;
                  r_rem   <= bus.cmd_len;
                  r_state <= (bus.cmd_len == '0) ? S_FIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_enb) begin
                  r_addr <= r_addr + 1'b1;
                  r_rem  <= r_rem - 1'b1;
                  if (w_last_in) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && bus.m_last) r_state <= S_FIN;
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Shift {valid,last} alongside the RAM read latency.
   always_ff @(posedge clkb or negedge rstb_n) begin
      if (!rstb_n) begin
         r_pv <= '0;
         r_pl <= '0;
      end else begin
         r_pv[0] <= w_enb;
         r_pl[0] <= w_last_in;
         for (int i = 1; i < L; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pl[i] <= r_pl[i-1];
         end
      end
   end

   // Fall-through FIFO; credit keeps it from ever overflowing.
   always_ff @(posedge clkb or negedge rstb_n) begin
      if (!rstb_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= {r_pl[L-1], bus.doutb};
            r_wp        <= f_inc(r_wp);
         end
         if (w_pop) r_rp <= f_inc(r_rp);
         if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
         else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_xpmwrap_sdpram_read_stream.sv
// Bench for the SDPRAM read-stream sequencer: RAM model,
// scoreboard of expected beats, table rows plus corner sequences.
module tb_xpmwrap_sdpram_read_stream;
   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int L     = 2;
   localparam int DEPTH = L + 2;

   logic clkb   = 1'b0;
   logic rstb_n = 1'b0;
   always #5 clkb = ~clkb;

   xpmwrap_sdpram_read_stream_if #(
      .ADDR_WIDTH_B(AW), .READ_DATA_WIDTH_B(DW)
   ) u_if ();

   xpmwrap_sdpram_read_stream #(
      .ADDR_WIDTH_B(AW), .READ_DATA_WIDTH_B(DW),
      .READ_LATENCY_B(L), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clkb(clkb), .rstb_n(rstb_n), .bus(u_if.slave)
   );

   logic [DW-1:0] ram [64];
   logic [DW-1:0] rp [L];

   // RAM port-B model with L-cycle read latency, not reset.
   always @(posedge clkb) begin
      if (u_if.enb) rp[0] <= ram[u_if.addrb];
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
   end
   assign u_if.doutb = rp[L-1];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int beats, enb_cnt, done_cnt, done_cyc, first_v;
   int t_acc, dstart, rdy_mode;
   int addr_log[$];
   logic [DW:0] sbq[$];
   logic prev_stall;
   logic [DW-1:0] prev_data;
   logic prev_last;

   always @(posedge clkb) cyc <= cyc + 1;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Consumer ready pattern selected by the main sequence.
   always @(posedge clkb) begin
      #1;
      case (rdy_mode)
         0: u_if.m_ready = 1'b1;
         1: u_if.m_ready = 1'($urandom_range(0, 1));
         2: u_if.m_ready = 1'b0;
         default: u_if.m_ready = ~u_if.m_ready;
      endcase
   end

   // Monitor: counts, stall stability, scoreboard pop on handshake.
   always @(negedge clkb) begin
      if (!rstb_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(u_if.m_valid), 64'd1);
            check("hold_data", 64'(u_if.m_data), 64'(prev_data));
            check("hold_last", 64'(u_if.m_last), 64'(prev_last));
         end
         if (u_if.enb) begin
            enb_cnt++;
            addr_log.push_back(int'(u_if.addrb));
         end
         if (u_if.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (u_if.m_valid && first_v < 0) first_v = cyc;
         if (u_if.m_valid && u_if.m_ready) begin
            beats++;
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL extra_beat: got data %0h, none expected",
                        u_if.m_data);
            end else begin
               logic [DW:0] e;
               e = sbq.pop_front();
               check("beat_data", 64'(u_if.m_data), 64'(e[DW-1:0]));
               check("beat_last", 64'(u_if.m_last), 64'(e[DW]));
            end
         end
         prev_stall = u_if.m_valid && !u_if.m_ready;
         prev_data  = u_if.m_data;
         prev_last  = u_if.m_last;
      end
   end

   task automatic do_cmd(input int a, input int l);
      @(posedge clkb);
      #1;
      beats   = 0;
      enb_cnt = 0;
      first_v = -1;
      addr_log.delete();
      dstart  = done_cnt;
      for (int i = 0; i < l; i++)
         sbq.push_back({(i == l - 1), ram[(a + i) % 64]});
      u_if.cmd_addr  = a[AW-1:0];
      u_if.cmd_len   = l[AW:0];
      u_if.cmd_valid = 1'b1;
      @(negedge clkb);
      t_acc = cyc;
      check("cmd_ready", 64'(u_if.cmd_ready), 64'd1);
      @(posedge clkb);
      #1;
      u_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && done_cnt == dstart; k++)
         @(posedge clkb);
      check("done_seen", 64'(done_cnt - dstart), 64'd1);
      @(posedge clkb);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(u_if.cmd_ready), 64'd1);
      check({tag, "_enb"}, 64'(u_if.enb), 64'd0);
      check({tag, "_addrb"}, 64'(u_if.addrb), 64'd0);
      check({tag, "_m_valid"}, 64'(u_if.m_valid), 64'd0);
      check({tag, "_m_last"}, 64'(u_if.m_last), 64'd0);
      check({tag, "_m_data"}, 64'(u_if.m_data), 64'd0);
      check({tag, "_busy"}, 64'(u_if.busy), 64'd0);
      check({tag, "_done"}, 64'(u_if.done), 64'd0);
      check({tag, "_regceb"}, 64'(u_if.regceb), 64'd1);
   endtask

   typedef struct {
      int addr;
      int len;
      int mode;
      int exp_beats;
      int exp_enb;
      int exp_done_lat;
      int exp_first_lat;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{62, 4, 0, 4, 4, 8, 4};
      tbl[1] = '{0, 64, 0, 64, 64, 68, 4};
      tbl[2] = '{10, 7, 1, 7, 7, -1, 4};
      tbl[3] = '{63, 1, 0, 1, 1, 5, 4};
      tbl[4] = '{0, 0, 0, 0, 0, 1, -1};
      tbl[5] = '{33, 3, 1, 3, 3, -1, 4};

      for (int i = 0; i < 64; i++) ram[i] = 32'h100 + 32'(i);
      u_if.cmd_valid = 1'b0;
      u_if.cmd_addr  = '0;
      u_if.cmd_len   = '0;
      rdy_mode = 0;
      beats = 0; enb_cnt = 0; done_cnt = 0;
      done_cyc = -1; first_v = -1; dstart = 0;

      #3;
      check_reset_outputs("rst");
      repeat (2) @(posedge clkb);
      #1;
      rstb_n = 1'b1;

      // Basic read with exact timing.
      do_cmd(5, 4);
      wait_done(40);
      check("basic_first_lat", 64'(first_v - t_acc), 64'd4);
      check("basic_done_lat", 64'(done_cyc - t_acc), 64'd8);
      check("basic_beats", 64'(beats), 64'd4);
      check("basic_enb", 64'(enb_cnt), 64'd4);

      // Table rows: wrap, full length, random ready, zero length.
      foreach (tbl[r]) begin
         int fl;
         rdy_mode = tbl[r].mode;
         do_cmd(tbl[r].addr, tbl[r].len);
         wait_done(tbl[r].len * 8 + 50);
         check("row_beats", 64'(beats), 64'(tbl[r].exp_beats));
         check("row_enb", 64'(enb_cnt), 64'(tbl[r].exp_enb));
         fl = (first_v < 0) ? -1 : first_v - t_acc;
         check("row_first_lat", 64'(fl), 64'(tbl[r].exp_first_lat));
         if (tbl[r].exp_done_lat >= 0)
            check("row_done_lat", 64'(done_cyc - t_acc),
                  64'(tbl[r].exp_done_lat));
         for (int j = 0; j < addr_log.size() && j < tbl[r].len; j++)
            check("row_addrb", 64'(addr_log[j]),
                  64'((tbl[r].addr + j) % 64));
         check("row_sb_empty", 64'(sbq.size()), 64'd0);
         rdy_mode = 0;
      end

      // Backpressure: stall, then toggle ready.
      rdy_mode = 2;
      do_cmd(20, 10);
      repeat (20) @(posedge clkb);
      #1;
      check("stall_enb", 64'(enb_cnt), 64'(DEPTH));
      check("stall_beats", 64'(beats), 64'd0);
      rdy_mode = 3;
      wait_done(200);
      check("bp_beats", 64'(beats), 64'd10);
      check("bp_sb_empty", 64'(sbq.size()), 64'd0);
      rdy_mode = 0;

      // Reset in the middle of a command.
      do_cmd(40, 10);
      for (int k = 0; k < 50 && beats < 3; k++) begin
         @(posedge clkb);
         #1;
      end
      check("mid_beats", 64'(beats), 64'd3);
      #1;
      rstb_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      sbq.delete();
      repeat (2) @(posedge clkb);
      #1;
      rstb_n = 1'b1;
      beats = 0;
      first_v = -1;
      repeat (6) @(posedge clkb);
      #1;
      check("no_stale_beats", 64'(beats), 64'd0);
      check("no_stale_valid", 64'(first_v), 64'(-1));
      do_cmd(7, 2);
      wait_done(40);
      check("post_rst_beats", 64'(beats), 64'd2);
      check("post_rst_sb", 64'(sbq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
